// File: rtl/coin_input_conditioner.sv
// Coin/buy input conditioner: synchronises and debounces the raw vending-machine
// lines, then arbitrates them into single-cycle, guard-spaced coin/buy pulses.
module coin_input_conditioner #(
    parameter int DB_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_raw,
    input  logic             buy_raw,
    output logic             coin,
    output logic             buy,
    output logic             busy,
    output logic [CNT_W-1:0] coin_total,
    output logic             drop_err
);

    localparam int DCW = $clog2(DB_CYCLES);
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DCW-1:0] DB_LAST  = DCW'(DB_CYCLES - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

    typedef enum logic {IDLE, GAP} state_t;

    // channel 0 = coin, channel 1 = buy
    logic [1:0]     sync_p0;
    logic [1:0]     sync_p1;
    logic [1:0]     db;
    logic [1:0]     rise;
    logic [DCW-1:0] db_cnt [2];

    state_t         state;
    state_t         state_nxt;
    logic [GCW-1:0] gap_cnt;
    logic           gap_done;
    logic           coin_req;
    logic           buy_req;
    logic           grant_coin;
    logic           grant_buy;

    // ---- stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {buy_raw, coin_raw};
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce: accept a level after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                db[i]     <= 1'b0;
                db_cnt[i] <= '0;
            end else if (sync_p1[i] != db[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DCW'(1);
                end
            end else begin
                db_cnt[i] <= '0;
            end
        end
    end

    // A rising edge is flagged on the same posedge that db goes high.
    always_comb begin
        rise = '0;
        for (int i = 0; i < 2; i++) begin
            rise[i] = sync_p1[i] & ~db[i] & (db_cnt[i] == DB_LAST);
        end
    end

    // ---- arbiter FSM
    assign gap_done = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (coin_req | buy_req) state_nxt = GAP;
            GAP:     if (gap_done)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_coin = (state == IDLE) & coin_req;
        grant_buy  = (state == IDLE) & ~coin_req & buy_req;
    end

    always_ff @(posedge clk) begin
        if (rst || state != GAP || gap_done) gap_cnt <= '0;
        else                                 gap_cnt <= gap_cnt + GCW'(1);
    end

    // ---- requests, pulses and status
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_req   <= 1'b0;
            buy_req    <= 1'b0;
            drop_err   <= 1'b0;
            coin       <= 1'b0;
            buy        <= 1'b0;
            coin_total <= '0;
        end else begin
            coin_req <= rise[0] | (coin_req & ~grant_coin);
            buy_req  <= rise[1] | (buy_req & ~grant_buy);
            // an edge arriving while its request is still latched is lost
            drop_err <= drop_err | (rise[0] & coin_req & ~grant_coin)
                                 | (rise[1] & buy_req & ~grant_buy);
            coin     <= grant_coin;
            buy      <= grant_buy;
            if (grant_coin && !(&coin_total)) coin_total <= coin_total + CNT_W'(1);
        end
    end

    assign busy = (state != IDLE) | coin_req | buy_req;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: two instances (guard gap 2 and 20) checked every
// cycle against a history-window/timestamp model, plus literal latency checks.
`timescale 1ns/1ps
module tb_coin_input_conditioner;

    localparam int DB        = 4;
    localparam int CW        = 8;
    localparam int HL        = DB + 2;
    localparam int TOTAL_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic coin_raw;
    logic buy_raw;

    logic          coin_a, buy_a, busy_a, drop_a;
    logic [CW-1:0] total_a;
    logic          coin_b, buy_b, busy_b, drop_b;
    logic [CW-1:0] total_b;

    coin_input_conditioner #(.DB_CYCLES(DB), .GAP_CYCLES(2), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .coin_raw(coin_raw), .buy_raw(buy_raw),
        .coin(coin_a), .buy(buy_a), .busy(busy_a), .coin_total(total_a), .drop_err(drop_a)
    );

    coin_input_conditioner #(.DB_CYCLES(DB), .GAP_CYCLES(20), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .coin_raw(coin_raw), .buy_raw(buy_raw),
        .coin(coin_b), .buy(buy_b), .busy(busy_b), .coin_total(total_b), .drop_err(drop_b)
    );

    initial forever #5 clk = ~clk;

    logic          d_coin [2];
    logic          d_buy  [2];
    logic          d_busy [2];
    logic          d_drop [2];
    logic [CW-1:0] d_total[2];
    assign d_coin[0] = coin_a;   assign d_coin[1] = coin_b;
    assign d_buy[0]  = buy_a;    assign d_buy[1]  = buy_b;
    assign d_busy[0] = busy_a;   assign d_busy[1] = busy_b;
    assign d_drop[0] = drop_a;   assign d_drop[1] = drop_b;
    assign d_total[0] = total_a; assign d_total[1] = total_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    // model state
    bit hc[HL];
    bit hb[HL];
    bit db_c, db_b;
    int gap_of[2] = '{2, 20};
    bit m_creq[2], m_breq[2], m_drop[2];
    bit e_coin[2], e_buy[2], e_busy[2];
    int m_total[2], m_next_ok[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a level is accepted once the last DB samples seen through the two-flop
    // delay all disagree with it; pulses are granted whenever the cycle index has
    // reached the time the previous pulse's guard gap allows.
    task automatic model_step();
        bit rc, rb, c1, c0, b1, b0;
        if (rst) begin
            for (int j = 0; j < HL; j++) begin hc[j] = 0; hb[j] = 0; end
            db_c = 0; db_b = 0;
            for (int i = 0; i < 2; i++) begin
                m_creq[i] = 0; m_breq[i] = 0; m_drop[i] = 0;
                e_coin[i] = 0; e_buy[i] = 0; e_busy[i] = 0;
                m_total[i] = 0; m_next_ok[i] = 0;
            end
            cmp_en = 1'b1;
        end else begin
            for (int j = HL - 1; j > 0; j--) begin hc[j] = hc[j-1]; hb[j] = hb[j-1]; end
            hc[0] = coin_raw; hb[0] = buy_raw;
            c1 = 1; c0 = 1; b1 = 1; b0 = 1;
            for (int j = 2; j < HL; j++) begin
                if (!hc[j]) c1 = 0; else c0 = 0;
                if (!hb[j]) b1 = 0; else b0 = 0;
            end
            rc = 0; rb = 0;
            if (!db_c && c1) begin db_c = 1; rc = 1; end
            else if (db_c && c0) db_c = 0;
            if (!db_b && b1) begin db_b = 1; rb = 1; end
            else if (db_b && b0) db_b = 0;
            for (int i = 0; i < 2; i++) begin
                e_coin[i] = 0; e_buy[i] = 0;
                if (cyc >= m_next_ok[i]) begin
                    if (m_creq[i]) begin
                        e_coin[i] = 1; m_creq[i] = 0;
                        if (m_total[i] < TOTAL_MAX) m_total[i]++;
                        m_next_ok[i] = cyc + gap_of[i] + 1;
                    end else if (m_breq[i]) begin
                        e_buy[i] = 1; m_breq[i] = 0;
                        m_next_ok[i] = cyc + gap_of[i] + 1;
                    end
                end
                if (rc) begin if (m_creq[i]) m_drop[i] = 1; m_creq[i] = 1; end
                if (rb) begin if (m_breq[i]) m_drop[i] = 1; m_breq[i] = 1; end
                e_busy[i] = (cyc < m_next_ok[i] - 1) || m_creq[i] || m_breq[i];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("m%0d_coin", i),  d_coin[i],  e_coin[i]);
                check($sformatf("m%0d_buy", i),   d_buy[i],   e_buy[i]);
                check($sformatf("m%0d_busy", i),  d_busy[i],  e_busy[i]);
                check($sformatf("m%0d_drop", i),  d_drop[i],  m_drop[i]);
                check($sformatf("m%0d_total", i), d_total[i], m_total[i]);
                check($sformatf("m%0d_overlap", i), d_coin[i] & d_buy[i], 0);
            end
        end
    end

    int ncoin_a = 0;
    int nbuy_a  = 0;
    initial forever begin
        @(negedge clk);
        if (coin_a === 1'b1) ncoin_a++;
        if (buy_a === 1'b1)  nbuy_a++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int sel, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((sel == 0 && coin_a === 1'b1) || (sel == 1 && buy_a === 1'b1)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: no pulse within %0d cycles", (sel == 0) ? "coin" : "buy", limit);
        end
    endtask

    initial begin
        int k, s, t, tc, tb, n0, r;
        rst = 1'b1; coin_raw = 1'b0; buy_raw = 1'b0;
        idle(3);
        check("rst_coin", coin_a, 0);
        check("rst_buy", buy_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_total", total_a, 0);
        check("rst_drop", drop_a, 0);
        check("rst_total_b", total_b, 0);
        rst = 1'b0;
        idle(5);

        // steady coin: pulse after posedge k+DB+2
        k = cyc + 1; coin_raw = 1'b1;
        wait_pulse(0, 40, t);
        check("t2_latency", t, k + 6);
        idle(1);
        check("t2_total", total_a, 1);
        coin_raw = 1'b0;
        idle(15);

        // bounce 1,0,1,0 then steady high
        n0 = ncoin_a;
        coin_raw = 1'b1; idle(1); coin_raw = 1'b0; idle(1);
        coin_raw = 1'b1; idle(1); coin_raw = 1'b0; idle(1);
        s = cyc + 1; coin_raw = 1'b1;
        wait_pulse(0, 40, t);
        check("t3_latency", t, s + 6);
        idle(20);
        check("t3_pulses", ncoin_a - n0, 1);
        coin_raw = 1'b0;
        idle(15);

        // simultaneous coin and buy
        coin_raw = 1'b1; buy_raw = 1'b1;
        wait_pulse(0, 40, tc);
        wait_pulse(1, 40, tb);
        check("t4_spacing", tb - tc, 3);
        coin_raw = 1'b0; buy_raw = 1'b0;
        idle(40);

        // extra coin edges while the long-gap instance still holds buy and coin requests
        coin_raw = 1'b1; buy_raw = 1'b1; idle(4);
        coin_raw = 1'b0; buy_raw = 1'b0; idle(4);
        coin_raw = 1'b1; idle(4);
        coin_raw = 1'b0; idle(4);
        coin_raw = 1'b1; idle(4);
        coin_raw = 1'b0; idle(4);
        check("t5_drop_b", drop_b, 1);
        check("t5_drop_a", drop_a, 0);
        idle(80);

        // reset in GAP with buy pending, coin held high through reset
        coin_raw = 1'b1; buy_raw = 1'b1;
        wait_pulse(0, 40, tc);
        check("t6_busy_gap", busy_a, 1);
        rst = 1'b1; buy_raw = 1'b0;
        idle(3);
        rst = 1'b0; r = cyc + 1; n0 = nbuy_a;
        wait_pulse(0, 40, t);
        check("t6_release", t, r + 6);
        check("t6_no_buy", nbuy_a - n0, 0);
        check("t6_drop_clr", drop_b, 0);
        check("t6_total", total_a, 1);
        coin_raw = 1'b0;
        idle(12);

        for (int i = 0; i < 254; i++) begin
            coin_raw = 1'b1; idle(12);
            coin_raw = 1'b0; idle(12);
        end
        idle(30);
        check("t6_total_255_a", total_a, 255);
        check("t6_total_255_b", total_b, 255);
        for (int i = 0; i < 3; i++) begin
            coin_raw = 1'b1; idle(12);
            coin_raw = 1'b0; idle(12);
        end
        idle(30);
        check("t6_sat_a", total_a, 255);
        check("t6_sat_b", total_b, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
